core_quant_lanes: RTL
=====================

CORE_QUANT_LANES -- requirements
Module: core_quant_lanes

Interface
REQ-001 SHALL have parameter LANES, default 4, meaning parallel quantizer lanes per beat.
REQ-002 SHALL have parameter IDATA_WIDTH, default 24, meaning signed input width per lane.
REQ-003 SHALL have parameter ODATA_BIT, default 8, meaning signed output width per lane.
REQ-004 SHALL have parameters CDATA_SCALE_WIDTH (16), CDATA_BIAS_WIDTH (24) and CDATA_SHIFT_WIDTH (5), meaning unsigned scale, signed bias and unsigned shift widths.
REQ-005 SHALL have parameter NUM_CH, default 16, a power of two, meaning per-channel config table depth; CH_W = log2(NUM_CH).
REQ-006 SHALL use one clock and a synchronous, active-high reset: clk input 1 (rising-edge clock); rst input 1 (synchronous active-high reset).
REQ-007 SHALL have these config-write ports: cfg_we input 1; cfg_waddr input CH_W; cfg_scale input CDATA_SCALE_WIDTH; cfg_bias input CDATA_BIAS_WIDTH; cfg_shift input CDATA_SHIFT_WIDTH.
REQ-008 SHALL have cfg_round_mode input 1, meaning 0 = truncate (floor) and 1 = round-half-up.
REQ-009 SHALL have these input-stream ports: idata input LANES*IDATA_WIDTH (lane l at bits [l*IDATA_WIDTH +: IDATA_WIDTH]); idata_ch input CH_W (channel of lane 0); idata_valid input 1; idata_ready output 1.
REQ-010 SHALL have these output-stream ports: odata output LANES*ODATA_BIT; osat output LANES (per-lane saturation flag); odata_valid output 1; odata_ready input 1.
REQ-011 SHALL have these statistics ports: sat_cnt output 32 (running count of saturated lanes); sat_cnt_clr input 1.

Function
REQ-012 SHALL hold the config table as NUM_CH entries of {scale, bias, shift}; a write with cfg_we=1 updates entry cfg_waddr at the clock edge.
REQ-013 SHALL give lane l of a beat config entry (idata_ch+l) mod NUM_CH, with wrap-around.
REQ-014 SHALL read config and cfg_round_mode in the cycle the beat is accepted; a write in that same cycle is not visible to that beat and is visible to the next accepted beat.
REQ-015 SHALL use a 4-stage pipeline: S1 product = signed idata * {1'b0,scale}; S2 sum = product + sign-extended bias, with round bit rb = sum[shift-1] when shift>0, else 0; S3 shifted = (sum >>> shift) + (cfg_round_mode ? rb : 0); S4 saturate to ODATA_BIT and register into odata and osat.
REQ-016 SHALL compute with internal width TEMP = IDATA_WIDTH+CDATA_SCALE_WIDTH+2 signed, so bias add and round increment never wrap.
REQ-017 SHALL treat shift >= TEMP as an arithmetic shift yielding 0 or -1, with rb = sign bit.
REQ-018 SHALL saturate so that a result > 2^(ODATA_BIT-1)-1 outputs the maximum with osat=1, a result < -2^(ODATA_BIT-1) outputs the minimum with osat=1, and any other result passes through with osat=0.
REQ-019 SHALL accept a beat when idata_valid and idata_ready are both 1, and transfer an output when odata_valid and odata_ready are both 1.
REQ-020 SHALL compute stage enable en = ~odata_valid | odata_ready; all stages advance only when en=1, and idata_ready = en.
REQ-021 SHALL give 4-cycle latency from acceptance to odata_valid when not stalled, with throughput of one beat per cycle.
REQ-022 SHALL propagate bubbles as invalid stages without creating spurious outputs, and SHALL hold odata, osat and odata_valid stable while odata_valid=1 and odata_ready=0.
REQ-023 SHALL add popcount(osat) to sat_cnt on each output transfer, saturating at 2^32-1.
REQ-024 SHALL clear sat_cnt on sat_cnt_clr, and when a clear and an increment coincide, sat_cnt becomes the increment value.

Reset
REQ-025 SHALL, while rst=1 at a clock edge, set odata_valid=0, odata=0, osat=0, sat_cnt=0 and all stage valids to 0.
REQ-026 SHALL keep idata_ready=1 during reset.
REQ-027 SHALL reset every config entry to scale=1, bias=0, shift=0.
REQ-028 SHALL discard in-flight beats on reset mid-operation, and the first post-reset output SHALL come from a beat accepted after reset.

Verification
REQ-029 SHALL cover rounding (defaults, ch0 scale=3 bias=0 shift=2): lane0 idata=5 gives 4 with round=1 and 3 with round=0; idata=-5 gives -4 in both modes; idata=100 gives 75.
REQ-030 SHALL cover saturation (ch0 scale=1 shift=0): idata=1000 gives 127 with osat=1; idata=-1000 gives -128 with osat=1; idata=127 gives 127 with osat=0; after the output transfer with lanes at 1000 and -1000 and lanes 2-3 at 0, sat_cnt=2.
REQ-031 SHALL cover channel wrap: idata_ch=15 with ch15 scale=2 and ch0-2 scale=1, all lanes idata=10, gives lane outputs 20,10,10,10.
REQ-032 SHALL cover backpressure: stream 8 back-to-back beats, odata_ready=0 for cycles 5-9; no beat is lost or duplicated, order is preserved, and idata_ready=0 exactly while odata_valid=1 and odata_ready=0.
REQ-033 SHALL cover a config write race: ch0 scale changes 1 to 2 in the acceptance cycle of beat A (idata=10), then beat B (idata=10) follows; outputs are A=10 and B=20.
REQ-034 SHALL cover reset mid-stream: assert rst for 1 cycle with 3 beats in flight; all outputs and stage valids are 0, sat_cnt=0, and no stale beat emerges afterward.

Source files
------------

// File: rtl/core_quant_lanes.sv
// core_quant_lanes: LANES-wide per-channel scale/bias/shift quantizer.
// Four-stage pipeline with saturation and a running saturation counter.
module core_quant_lanes #(
   parameter int LANES             = 4,
   parameter int IDATA_WIDTH       = 24,
   parameter int ODATA_BIT         = 8,
   parameter int CDATA_SCALE_WIDTH = 16,
   parameter int CDATA_BIAS_WIDTH  = 24,
   parameter int CDATA_SHIFT_WIDTH = 5,
   parameter int NUM_CH            = 16,
   localparam int CH_W             = $clog2(NUM_CH)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          cfg_we,
   input  logic [CH_W-1:0]               cfg_waddr,
   input  logic [CDATA_SCALE_WIDTH-1:0]  cfg_scale,
   input  logic [CDATA_BIAS_WIDTH-1:0]   cfg_bias,
   input  logic [CDATA_SHIFT_WIDTH-1:0]  cfg_shift,
   input  logic                          cfg_round_mode,
   input  logic [LANES*IDATA_WIDTH-1:0]  idata,
   input  logic [CH_W-1:0]               idata_ch,
   input  logic                          idata_valid,
   output logic                          idata_ready,
   output logic [LANES*ODATA_BIT-1:0]    odata,
   output logic [LANES-1:0]              osat,
   output logic                          odata_valid,
   input  logic                          odata_ready,
   output logic [31:0]                   sat_cnt,
   input  logic                          sat_cnt_clr
);
   localparam int IW   = IDATA_WIDTH;
   localparam int OB   = ODATA_BIT;
   localparam int SW   = CDATA_SCALE_WIDTH;
   localparam int BW   = CDATA_BIAS_WIDTH;
   localparam int HW   = CDATA_SHIFT_WIDTH;
   localparam int TEMP = IW + SW + 2;

   typedef logic signed [TEMP-1:0] acc_t;

   localparam acc_t OMAX = {{(TEMP-OB+1){1'b0}}, {(OB-1){1'b1}}};
   localparam acc_t OMIN = {{(TEMP-OB+1){1'b1}}, {(OB-1){1'b0}}};

   logic [SW-1:0]        scale_q [NUM_CH];
   logic signed [BW-1:0] bias_q  [NUM_CH];
   logic [HW-1:0]        shift_q [NUM_CH];

   logic                 en;
   logic                 xfer;
   logic                 v1_q, v2_q, v3_q, ovalid_q;
   logic                 rm1_q, rm2_q;
   logic [CH_W-1:0]      ch_d    [LANES];
   acc_t                 prod_d  [LANES];
   acc_t                 prod1_q [LANES];
   logic signed [BW-1:0] bias_d  [LANES];
   logic signed [BW-1:0] bias1_q [LANES];
   logic [HW-1:0]        sh_d    [LANES];
   logic [HW-1:0]        sh1_q   [LANES];
   logic [HW-1:0]        sh2_q   [LANES];
   acc_t                 sum_d   [LANES];
   acc_t                 sum2_q  [LANES];
   acc_t                 mask_d  [LANES];
   logic [LANES-1:0]     rb_d, rb2_q;
   acc_t                 res_d   [LANES];
   acc_t                 res3_q  [LANES];
   logic [LANES*OB-1:0]  odata_d, odata_q;
   logic [LANES-1:0]     osat_d, osat_q;
   logic [31:0]          pc_d, satc_d, satc_q;
   logic [32:0]          satsum_d;

   assign en          = ~ovalid_q | odata_ready;
   assign xfer        = ovalid_q & odata_ready;
   assign idata_ready = en | rst;
   assign odata       = odata_q;
   assign osat        = osat_q;
   assign odata_valid = ovalid_q;
   assign sat_cnt     = satc_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            scale_q[i] <= SW'(1);
            bias_q[i]  <= '0;
            shift_q[i] <= '0;
         end
      end else if (cfg_we) begin
         scale_q[cfg_waddr] <= cfg_scale;
         bias_q[cfg_waddr]  <= cfg_bias;
         shift_q[cfg_waddr] <= cfg_shift;
      end
   end

   // S1: lane l uses channel idata_ch+l, wrapping in CH_W bits
   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         ch_d[l]   = idata_ch + CH_W'(l);
         prod_d[l] = acc_t'($signed(idata[l*IW +: IW]))
                   * acc_t'($signed({1'b0, scale_q[ch_d[l]]}));
         bias_d[l] = bias_q[ch_d[l]];
         sh_d[l]   = shift_q[ch_d[l]];
      end
   end

   always_comb begin
      rb_d = '0;
      for (int l = 0; l < LANES; l++) begin
         sum_d[l]  = prod1_q[l] + acc_t'(bias1_q[l]);
         mask_d[l] = acc_t'(1) << (sh1_q[l] - HW'(1));
         if (sh1_q[l] == '0)
            rb_d[l] = 1'b0;
         else if (int'(sh1_q[l]) >= TEMP)
            rb_d[l] = sum_d[l][TEMP-1];
         else
            rb_d[l] = |(sum_d[l] & mask_d[l]);
      end
   end

   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         res_d[l] = sum2_q[l] >>> sh2_q[l];
         if (rm2_q && rb2_q[l])
            res_d[l] = res_d[l] + acc_t'(1);
      end
   end

   always_comb begin
      odata_d = '0;
      osat_d  = '0;
      for (int l = 0; l < LANES; l++) begin
         if (res3_q[l] > OMAX) begin
            odata_d[l*OB +: OB] = OMAX[OB-1:0];
            osat_d[l]           = 1'b1;
         end else if (res3_q[l] < OMIN) begin
            odata_d[l*OB +: OB] = OMIN[OB-1:0];
            osat_d[l]           = 1'b1;
         end else begin
            odata_d[l*OB +: OB] = res3_q[l][OB-1:0];
         end
      end
   end

   // A clear coinciding with a transfer keeps only that transfer's count
   always_comb begin
      pc_d = '0;
      for (int l = 0; l < LANES; l++)
         pc_d = pc_d + 32'(osat_q[l]);
      satsum_d = {1'b0, satc_q} + {1'b0, pc_d};
      satc_d   = satc_q;
      if (sat_cnt_clr)
         satc_d = xfer ? pc_d : '0;
      else if (xfer)
         satc_d = satsum_d[32] ? '1 : satsum_d[31:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q     <= 1'b0;
         v2_q     <= 1'b0;
         v3_q     <= 1'b0;
         ovalid_q <= 1'b0;
         odata_q  <= '0;
         osat_q   <= '0;
         satc_q   <= '0;
      end else begin
         satc_q <= satc_d;
         if (en) begin
            v1_q     <= idata_valid;
            v2_q     <= v1_q;
            v3_q     <= v2_q;
            ovalid_q <= v3_q;
            if (v3_q) begin
               odata_q <= odata_d;
               osat_q  <= osat_d;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (en) begin
         prod1_q <= prod_d;
         bias1_q <= bias_d;
         sh1_q   <= sh_d;
         rm1_q   <= cfg_round_mode;
         sum2_q  <= sum_d;
         rb2_q   <= rb_d;
         sh2_q   <= sh1_q;
         rm2_q   <= rm1_q;
         res3_q  <= res_d;
      end
   end

endmodule
